seq_tail_lamp_ctrl: RTL and testbench

//  Parametrised sequential tail-lamp controller driving LAMPS lamps per side.

---
 rtl/seq_tail_lamp_ctrl.sv | 137 +++++++++++++
 tb/tb_seq_tail_lamp_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_tail_lamp_ctrl.sv
// ============================================================================
// Module      : seq_tail_lamp_ctrl
// Description : Sequential tail-lamp controller: turn/hazard sequencing,
//               brake overlay and PWM dimming of unlit lamps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tail_lamp_ctrl #(
    parameter int LAMPS    = 3,
    parameter int STEP_DIV = 4,
    parameter int DIM_BITS = 4,
    parameter int DIM_DUTY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         left,
    input  logic                         right,
    input  logic                         brk,
    input  logic                         hzd,
    input  logic                         rlight,
    output logic [2*LAMPS-1:0]           display,
    output logic [1:0]                   mode_o,
    output logic [$clog2(LAMPS+1)-1:0]   step_o
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [SW-1:0]       c_step_last = SW'(LAMPS);
    localparam logic [SW-1:0]       c_step_one  = SW'(1);
    localparam logic [PW-1:0]       c_presc_max = PW'(STEP_DIV - 1);
    localparam logic [DIM_BITS:0]   c_duty      = (DIM_BITS + 1)'(DIM_DUTY);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    mode_t                 r_mode;
    logic [SW-1:0]         r_step;
    logic [PW-1:0]         r_presc;
    logic                  r_brk;
    logic                  r_rlight;
    logic [DIM_BITS-1:0]   r_pwm;
    logic [2*LAMPS-1:0]    r_display;

    mode_t                 w_mode;
    logic [SW-1:0]         w_step_adv;
    logic [LAMPS-1:0]      w_lit_l;
    logic [LAMPS-1:0]      w_lit_r;
    logic                  w_dim;

    always_comb begin
        w_mode = MODE_IDLE;
        if (hzd || (left && right))
            w_mode = MODE_HAZARD;
        else if (left)
            w_mode = MODE_LEFT;
        else if (right)
            w_mode = MODE_RIGHT;
    end

    always_comb begin
        w_step_adv = '0;
        case (r_mode)
            MODE_LEFT, MODE_RIGHT: w_step_adv = (r_step == c_step_last) ? '0 : r_step + SW'(1);
            MODE_HAZARD:           w_step_adv = (r_step == c_step_one) ? '0 : c_step_one;
            default:               w_step_adv = '0;
        endcase
    end

    // Turn sequences grow outward from the inner lamps (bits LAMPS and LAMPS-1).
    always_comb begin
        w_lit_l = '0;
        w_lit_r = '0;
        for (int i = 0; i < LAMPS; i++) begin
            if (r_mode == MODE_LEFT && i < int'(r_step))
                w_lit_l[i] = 1'b1;
            if (r_mode == MODE_RIGHT && i < int'(r_step))
                w_lit_r[LAMPS-1-i] = 1'b1;
        end
        if (r_mode == MODE_HAZARD && r_step == c_step_one) begin
            w_lit_l = '1;
            w_lit_r = '1;
        end
        if (r_brk) begin
            case (r_mode)
                MODE_LEFT:  w_lit_r = '1;
                MODE_RIGHT: w_lit_l = '1;
                default: begin
                    w_lit_l = '1;
                    w_lit_r = '1;
                end
            endcase
        end
    end

    assign w_dim = r_rlight & ({1'b0, r_pwm} < c_duty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode    <= MODE_IDLE;
            r_step    <= '0;
            r_presc   <= '0;
            r_brk     <= 1'b0;
            r_rlight  <= 1'b0;
            r_pwm     <= '0;
            r_display <= '0;
        end else begin
            // A mode change takes priority over a coincident terminal count.
            if (w_mode != r_mode) begin
                r_mode  <= w_mode;
                r_step  <= (w_mode == MODE_IDLE) ? '0 : c_step_one;
                r_presc <= '0;
            end else if (r_presc == c_presc_max) begin
                r_presc <= '0;
                r_step  <= w_step_adv;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_brk     <= brk;
            r_rlight  <= rlight;
            r_pwm     <= r_pwm + DIM_BITS'(1);
            r_display <= {w_lit_l, w_lit_r} | {(2*LAMPS){w_dim}};
        end
    end

    assign display = r_display;
    assign mode_o  = r_mode;
    assign step_o  = r_step;

endmodule

`default_nettype wire

// File: tb/tb_seq_tail_lamp_ctrl.sv
// ============================================================================
// Module      : tb_seq_tail_lamp_ctrl
// Description : Self-checking bench for seq_tail_lamp_ctrl (vectors, corner
//               sequences and randomized run against an arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_tail_lamp_ctrl;

    localparam int L  = 3;
    localparam int SD = 4;
    localparam int DB = 4;
    localparam int DD = 4;
    localparam int W  = 2 * L;

    logic         clk;
    logic         rst;
    logic         left, right, brk, hzd, rlight;
    logic [W-1:0] display, display_full, display_zero;
    logic [1:0]   mode_o, mode_full, mode_zero;
    logic [1:0]   step_o, step_full, step_zero;

    int total = 0;
    int bad   = 0;

    seq_tail_lamp_ctrl #(.LAMPS(L), .STEP_DIV(SD), .DIM_BITS(DB), .DIM_DUTY(DD)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .brk(brk), .hzd(hzd),
        .rlight(rlight), .display(display), .mode_o(mode_o), .step_o(step_o));

    seq_tail_lamp_ctrl #(.LAMPS(L), .STEP_DIV(SD), .DIM_BITS(DB), .DIM_DUTY(16)) dut_full (
        .clk(clk), .rst(rst), .left(left), .right(right), .brk(brk), .hzd(hzd),
        .rlight(rlight), .display(display_full), .mode_o(mode_full), .step_o(step_full));

    seq_tail_lamp_ctrl #(.LAMPS(L), .STEP_DIV(SD), .DIM_BITS(DB), .DIM_DUTY(0)) dut_zero (
        .clk(clk), .rst(rst), .left(left), .right(right), .brk(brk), .hzd(hzd),
        .rlight(rlight), .display(display_zero), .mode_o(mode_zero), .step_o(step_zero));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    // Reference model: time since mode entry, plain arithmetic for step and pattern.
    int           m_mode, m_n, m_pwm;
    bit           m_brk, m_rl;
    logic [W-1:0] m_disp;

    function automatic int decode(bit l, bit r, bit h);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    function automatic int step_of(int md, int n);
        case (md)
            1, 2:    return (1 + n / SD) % (L + 1);
            3:       return ((n / SD) % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] pattern(int md, int s, bit b, bit rl, int pwm);
        int full = (1 << L) - 1;
        int ll = 0;
        int rr = 0;
        if (md == 1) ll = (1 << s) - 1;
        if (md == 2) rr = ((1 << s) - 1) << (L - s);
        if (md == 3 && s == 1) begin ll = full; rr = full; end
        if (b) begin
            if (md == 0 || md == 3) begin ll = full; rr = full; end
            if (md == 1) rr = full;
            if (md == 2) ll = full;
        end
        if (rl && pwm < DD) begin ll = full; rr = full; end
        return W'((ll << L) | rr);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_pwm = 0; m_brk = 0; m_rl = 0; m_disp = '0;
    endtask

    task automatic tick();
        int dec;
        @(posedge clk);
        m_disp = pattern(m_mode, step_of(m_mode, m_n), m_brk, m_rl, m_pwm);
        dec = decode(left, right, hzd);
        if (dec != m_mode) begin
            m_mode = dec;
            m_n = 0;
        end else begin
            m_n++;
        end
        m_brk = brk;
        m_rl  = rlight;
        m_pwm = (m_pwm + 1) % (1 << DB);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    typedef struct {
        bit         rs;
        bit         l, r, b, h, rl;
        int         reps;
        logic [5:0] disp;
        int         mode;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rs, bit l, bit r, bit b, bit h, bit rl,
                                int reps, logic [5:0] disp, int mode);
        vec_t v;
        v.rs = rs; v.l = l; v.r = r; v.b = b; v.h = h; v.rl = rl;
        v.reps = reps; v.disp = disp; v.mode = mode;
        return v;
    endfunction

    initial begin
        int cnt[W];
        int full_ok, zero_ok;

        rst = 1'b0;
        {left, right, brk, hzd, rlight} = '0;

        //              rs l  r  b  h  rl reps disp       mode
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 1, 6'b000000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 6'b001000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 6'b011000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 6'b111000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 6'b000000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 6'b001000, 1));
        tv.push_back(mk(1, 0, 1, 1, 0, 0, 1, 6'b000000, 2));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 4, 6'b111100, 2));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 4, 6'b111110, 2));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 4, 6'b111111, 2));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 4, 6'b111000, 2));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 1, 6'b111100, 2));
        tv.push_back(mk(1, 0, 0, 0, 1, 0, 1, 6'b000000, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 4, 6'b111111, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 4, 6'b000000, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 4, 6'b111111, 3));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 1, 6'b000000, 3));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 6, 6'b111111, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6'b111111, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 4, 6'b000000, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 6'b111111, 3));
        tv.push_back(mk(1, 1, 1, 0, 0, 0, 1, 6'b000000, 3));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 4, 6'b111111, 3));
        tv.push_back(mk(0, 1, 1, 0, 0, 0, 4, 6'b000000, 3));
        tv.push_back(mk(1, 1, 0, 0, 1, 0, 1, 6'b000000, 3));
        tv.push_back(mk(0, 1, 0, 0, 1, 0, 4, 6'b111111, 3));
        // Left to right switch during left step 2: prescaler restarts.
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 1, 6'b000000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 6'b001000, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 6'b011000, 1));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 6'b011000, 2));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 4, 6'b000100, 2));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 6'b000110, 2));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rs) begin
                {left, right, brk, hzd, rlight} = '0;
                do_reset();
                chk($sformatf("vec%0d_rst_disp", i), 32'(display), 32'h0);
                chk($sformatf("vec%0d_rst_mode", i), 32'(mode_o), 32'h0);
            end
            left = tv[i].l; right = tv[i].r; brk = tv[i].b;
            hzd = tv[i].h; rlight = tv[i].rl;
            for (int k = 0; k < tv[i].reps; k++) begin
                tick();
                chk($sformatf("vec%0d_disp", i), 32'(display), 32'(tv[i].disp));
                chk($sformatf("vec%0d_mode", i), 32'(mode_o), 32'(tv[i].mode));
            end
        end

        // Dimming duty in IDLE, plus the never-on and always-on duty extremes.
        {left, right, brk, hzd, rlight} = '0;
        do_reset();
        rlight = 1'b1;
        tick();
        tick();
        for (int b = 0; b < W; b++) cnt[b] = 0;
        full_ok = 0;
        zero_ok = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            for (int b = 0; b < W; b++) if (display[b]) cnt[b]++;
            if (display_full == '1) full_ok++;
            if (display_zero == '0) zero_ok++;
        end
        for (int b = 0; b < W; b++) chk($sformatf("dim_bit%0d_cnt", b), 32'(cnt[b]), 32'd4);
        chk("dim_full_cnt", 32'(full_ok), 32'd16);
        chk("dim_zero_cnt", 32'(zero_ok), 32'd16);

        // Asynchronous reset between edges in the middle of a hazard.
        rlight = 1'b0;
        do_reset();
        hzd = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_pre_disp", 32'(display), 32'h3f);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_disp", 32'(display), 32'h0);
        chk("arst_mode", 32'(mode_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst_rel1_disp", 32'(display), 32'h0);
        chk("arst_rel1_mode", 32'(mode_o), 32'd3);
        tick();
        chk("arst_rel2_disp", 32'(display), 32'h3f);

        // Randomized run against the model.
        {left, right, brk, hzd, rlight} = '0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                left   = $urandom_range(0, 1) == 1;
                right  = $urandom_range(0, 1) == 1;
                brk    = $urandom_range(0, 1) == 1;
                hzd    = $urandom_range(0, 3) == 0;
                rlight = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
            chk("rnd_disp", 32'(display), 32'(m_disp));
            chk("rnd_mode", 32'(mode_o), 32'(m_mode));
            chk("rnd_step", 32'(step_o), 32'(step_of(m_mode, m_n)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
